axis_data_chk: RTL and testbench

- AXI-Stream slave that sinks and checks packets from the team's incrementing-pattern stream generator.
- Accepts beats under a configurable backpressure pattern and checks each one: data increments from 1 per beat, tkeep is all-ones, tlast appears on beat PKT_LEN only.
- Reports per-packet pass/fail, sticky error flags and saturating packet/error counters to ILA/VIO or a CPU status register.

---
 rtl/axis_data_chk.sv | 212 +++++++++++++++++++++
 tb/tb_axis_data_chk.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_data_chk.sv
// ---------------------------------------------------------------------------
// axis_data_chk
//
// AXI-Stream sink that consumes and checks packets from the incrementing-
// pattern stream generator. Each packet must carry tdata = 1, 2, 3, ... (one
// increment per beat, wrapping at 2^DATA_W), tkeep all-ones on every beat and
// tlast on beat PKT_LEN only. Results go to per-packet status pulses, sticky
// error flags and saturating counters for an ILA/VIO or a CPU status register.
//
// Ports
//   aclk, aresetn   clock, synchronous active-low reset
//   start_check     level; arms reception while high
//   bp_en           1: tready follows the rotating BP_PATTERN, 0: tready high
//   clr_stat        one-cycle clear of sticky flags and counters
//   s_axis_*        AXI-Stream slave (tvalid/tready/tdata/tkeep/tlast)
//   pkt_done        one-cycle pulse while the packet result is presented
//   pkt_ok          qualified by pkt_done; 1 = packet had no error
//   err_data        sticky: tdata mismatch seen
//   err_keep        sticky: tkeep not all-ones seen
//   err_len         sticky: tlast early or missing
//   pkt_cnt         packets completed, saturating
//   err_cnt         failed packets, saturating
//   fsm_state       debug view of the control FSM
//
// Handshake: a beat transfers on a rising aclk edge where s_axis_tvalid and
// s_axis_tready are both high. tready is a register whose next value is
// derived from the next FSM state, so it drops on the same edge that accepts
// the tlast beat and no beat is ever offered ready without being consumed.
// tvalid while tready is low has no effect.
// ---------------------------------------------------------------------------
module axis_data_chk #(
    parameter int          DATA_W     = 32,
    parameter int          PKT_LEN    = 11,
    parameter logic [7:0]  BP_PATTERN = 8'b1011_0110,
    parameter int          CNT_W      = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start_check,
    input  logic                  bp_en,
    input  logic                  clr_stat,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tlast,
    output logic                  pkt_done,
    output logic                  pkt_ok,
    output logic                  err_data,
    output logic                  err_keep,
    output logic                  err_len,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [1:0]            fsm_state
);

    localparam int KEEP_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Length compared on 9 bits so beat_cnt+1 never wraps back into range.
    localparam logic [8:0] LEN9 = 9'(PKT_LEN);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [7:0]        bp_reg;
    logic [7:0]        bp_nxt;
    logic              tready_nxt;
    logic [DATA_W-1:0] expected;
    logic [7:0]        beat_cnt;
    logic [8:0]        beat_inc;
    logic              pkt_err;
    logic              pkt_err_nxt;
    logic              beat_acc;
    logic              data_bad;
    logic              keep_bad;
    logic              len_early;
    logic              len_miss;
    logic              pkt_end;
    logic              enter_recv;

    assign fsm_state = state;

    // -----------------------------------------------------------------------
    // Per-beat checks
    // -----------------------------------------------------------------------
    always_comb begin
        beat_acc  = 1'b0;
        data_bad  = 1'b0;
        keep_bad  = 1'b0;
        len_early = 1'b0;
        len_miss  = 1'b0;
        pkt_end   = 1'b0;
        beat_inc  = {1'b0, beat_cnt} + 9'd1;

        beat_acc = (state == ST_RECV) && s_axis_tvalid && s_axis_tready;
        if (beat_acc) begin
            data_bad  = (s_axis_tdata != expected);
            keep_bad  = (s_axis_tkeep != {KEEP_W{1'b1}});
            len_early = s_axis_tlast && (beat_inc < LEN9);
            // beat_cnt only passes PKT_LEN once per packet, so a missing
            // tlast can be flagged at most once; later beats keep being
            // data-checked until tlast finally arrives.
            len_miss  = !s_axis_tlast && (beat_inc == LEN9);
            pkt_end   = s_axis_tlast;
        end

        pkt_err_nxt = pkt_err | data_bad | keep_bad | len_early | len_miss;
    end

    // -----------------------------------------------------------------------
    // FSM next state, backpressure pattern and registered tready
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = start_check ? ST_RECV : ST_IDLE;
            ST_RECV: state_nxt = pkt_end ? ST_DONE : ST_RECV;
            ST_DONE: state_nxt = start_check ? ST_RECV : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        enter_recv = (state != ST_RECV) && (state_nxt == ST_RECV);

        // Pattern restarts at bit0 on every entry to RECV, then rotates right
        // once per RECV cycle whether or not a beat transferred.
        if (enter_recv) begin
            bp_nxt = BP_PATTERN;
        end else if (state == ST_RECV) begin
            bp_nxt = {bp_reg[0], bp_reg[7:1]};
        end else begin
            bp_nxt = bp_reg;
        end

        if (state_nxt == ST_RECV) begin
            tready_nxt = bp_en ? bp_nxt[0] : 1'b1;
        end else begin
            tready_nxt = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            bp_reg        <= BP_PATTERN;
            s_axis_tready <= 1'b0;
            expected      <= DATA_W'(1);
            beat_cnt      <= 8'd0;
            pkt_err       <= 1'b0;
            pkt_done      <= 1'b0;
            pkt_ok        <= 1'b0;
            err_data      <= 1'b0;
            err_keep      <= 1'b0;
            err_len       <= 1'b0;
            pkt_cnt       <= '0;
            err_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            bp_reg        <= bp_nxt;
            s_axis_tready <= tready_nxt;

            if (enter_recv) begin
                expected <= DATA_W'(1);
                beat_cnt <= 8'd0;
                pkt_err  <= 1'b0;
            end else if (beat_acc) begin
                expected <= expected + DATA_W'(1);
                if (beat_cnt != 8'hFF) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
                pkt_err <= pkt_err_nxt;
            end

            // Result is presented during the single DONE cycle.
            pkt_done <= pkt_end;
            pkt_ok   <= pkt_end && !pkt_err_nxt;

            // clr_stat takes priority over any update landing on this edge.
            if (clr_stat) begin
                err_data <= 1'b0;
                err_keep <= 1'b0;
                err_len  <= 1'b0;
                pkt_cnt  <= '0;
                err_cnt  <= '0;
            end else begin
                if (data_bad) begin
                    err_data <= 1'b1;
                end
                if (keep_bad) begin
                    err_keep <= 1'b1;
                end
                if (len_early || len_miss) begin
                    err_len <= 1'b1;
                end
                if (pkt_end) begin
                    if (pkt_cnt != {CNT_W{1'b1}}) begin
                        pkt_cnt <= pkt_cnt + CNT_W'(1);
                    end
                    if (pkt_err_nxt && (err_cnt != {CNT_W{1'b1}})) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_data_chk.sv
// ---------------------------------------------------------------------------
// tb_axis_data_chk
//
// Directed and randomized stimulus for axis_data_chk. Each packet is built as
// a list of beats; the reference model judges the list as a whole (any beat
// data != its 1-based index, any partial tkeep, tlast position != PKT_LEN)
// and keeps running totals for the counters and sticky flags.
// ---------------------------------------------------------------------------
module tb_axis_data_chk;

  localparam int DATA_W  = 32;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int PKT_LEN = 11;
  localparam int CNT_W   = 16;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              start_check;
  logic              bp_en;
  logic              clr_stat;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] s_axis_tdata;
  logic [KEEP_W-1:0] s_axis_tkeep;
  logic              s_axis_tlast;
  logic              pkt_done;
  logic              pkt_ok;
  logic              err_data;
  logic              err_keep;
  logic              err_len;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [1:0]        fsm_state;

  axis_data_chk #(
    .DATA_W    (DATA_W),
    .PKT_LEN   (PKT_LEN),
    .BP_PATTERN(8'b1011_0110),
    .CNT_W     (CNT_W)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .start_check  (start_check),
    .bp_en        (bp_en),
    .clr_stat     (clr_stat),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .pkt_done     (pkt_done),
    .pkt_ok       (pkt_ok),
    .err_data     (err_data),
    .err_keep     (err_keep),
    .err_len      (err_len),
    .pkt_cnt      (pkt_cnt),
    .err_cnt      (err_cnt),
    .fsm_state    (fsm_state)
  );

  // clock
  always #5 aclk = ~aclk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model totals
  int m_pkt = 0;
  int m_err = 0;
  bit m_ed  = 1'b0;
  bit m_ek  = 1'b0;
  bit m_el  = 1'b0;

  // packet under construction
  logic [DATA_W-1:0] pd[$];
  logic [KEEP_W-1:0] pk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_clean(input int len);
    pd.delete();
    pk.delete();
    for (int i = 0; i < len; i++) begin
      pd.push_back(DATA_W'(i + 1));
      pk.push_back({KEEP_W{1'b1}});
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_pkt_cnt"},  32'(pkt_cnt),  32'(m_pkt));
    chk({tag, "_err_cnt"},  32'(err_cnt),  32'(m_err));
    chk({tag, "_err_data"}, 32'(err_data), 32'(m_ed));
    chk({tag, "_err_keep"}, 32'(err_keep), 32'(m_ek));
    chk({tag, "_err_len"},  32'(err_len),  32'(m_el));
  endtask

  // Drives the current pd/pk list. stop_after < size leaves the packet
  // unfinished (used for the reset-abort case). clr_on_last pulses clr_stat on
  // the edge that accepts the tlast beat.
  task automatic run_pkt(input string tag, input bit bp, input int dens,
                         input int stop_after, input bit clr_on_last);
    int idx;
    int k;
    int guard;
    int n;
    bit acc;
    bit ed;
    bit ek;
    bit el;
    bit ok;
    logic [7:0] pat;
    pat   = 8'b1011_0110;
    n     = pd.size();
    idx   = 0;
    k     = 0;
    guard = 0;
    @(negedge aclk);
    start_check = 1'b1;
    bp_en       = bp;
    @(posedge aclk);
    while (idx < stop_after && guard < 1000) begin
      @(negedge aclk);
      clr_stat = 1'b0;
      chk({tag, "_tready"}, 32'(s_axis_tready), bp ? 32'(pat[k % 8]) : 32'd1);
      chk({tag, "_no_early_done"}, 32'(pkt_done), 32'd0);
      s_axis_tvalid = ($urandom_range(0, 99) < dens);
      s_axis_tdata  = pd[idx];
      s_axis_tkeep  = pk[idx];
      s_axis_tlast  = (idx == n - 1);
      acc = s_axis_tvalid && s_axis_tready;
      if (clr_on_last && acc && idx == n - 1) clr_stat = 1'b1;
      @(posedge aclk);
      if (acc) idx++;
      k++;
      guard++;
    end
    chk({tag, "_beats_accepted"}, 32'(idx), 32'(stop_after));
    if (stop_after < n) return;

    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    start_check   = 1'b0;
    clr_stat      = 1'b0;

    ed = 1'b0;
    ek = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (pd[i] != DATA_W'(i + 1)) ed = 1'b1;
      if (pk[i] != {KEEP_W{1'b1}}) ek = 1'b1;
    end
    el = (n != PKT_LEN);
    ok = !(ed || ek || el);
    if (clr_on_last) begin
      m_pkt = 0; m_err = 0; m_ed = 0; m_ek = 0; m_el = 0;
    end else begin
      if (m_pkt < 65535) m_pkt++;
      if (!ok && m_err < 65535) m_err++;
      m_ed |= ed; m_ek |= ek; m_el |= el;
    end

    chk({tag, "_pkt_done"}, 32'(pkt_done), 32'd1);
    chk({tag, "_pkt_ok"}, 32'(pkt_ok), 32'(ok));
    chk({tag, "_tready_done"}, 32'(s_axis_tready), 32'd0);
    chk_status(tag);
    @(posedge aclk);
    @(negedge aclk);
    chk({tag, "_done_pulse_end"}, 32'(pkt_done), 32'd0);
    chk({tag, "_tready_idle"}, 32'(s_axis_tready), 32'd0);
  endtask

  initial begin
    int len;
    // reset
    aresetn       = 1'b0;
    start_check   = 1'b0;
    bp_en         = 1'b0;
    clr_stat      = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_tready", 32'(s_axis_tready), 32'd0);
    chk("reset_pkt_done", 32'(pkt_done), 32'd0);
    chk("reset_pkt_ok", 32'(pkt_ok), 32'd0);
    chk_status("reset");
    aresetn = 1'b1;

    // clean packet, no backpressure, tvalid always high
    build_clean(PKT_LEN);
    run_pkt("clean_nobp", 1'b0, 100, PKT_LEN, 1'b0);

    // clean packet under the rotating backpressure pattern
    build_clean(PKT_LEN);
    run_pkt("clean_bp", 1'b1, 100, PKT_LEN, 1'b0);

    // data error on beat 5, then a clean packet
    build_clean(PKT_LEN);
    pd[4] = 32'h7;
    run_pkt("data_err", 1'b0, 100, PKT_LEN, 1'b0);
    build_clean(PKT_LEN);
    run_pkt("after_data_err", 1'b1, 70, PKT_LEN, 1'b0);

    // early tlast on beat 7, then tlast missing until beat 13
    build_clean(7);
    run_pkt("early_tlast", 1'b0, 100, 7, 1'b0);
    build_clean(13);
    run_pkt("late_tlast", 1'b1, 100, 13, 1'b0);

    // keep error on beat 3, then clr_stat pulse
    build_clean(PKT_LEN);
    pk[2] = 4'b0111;
    run_pkt("keep_err", 1'b0, 80, PKT_LEN, 1'b0);
    @(negedge aclk);
    clr_stat = 1'b1;
    @(negedge aclk);
    clr_stat = 1'b0;
    m_pkt = 0; m_err = 0; m_ed = 0; m_ek = 0; m_el = 0;
    chk_status("after_clr");

    // clr_stat on the same edge as a failing packet's completion
    build_clean(PKT_LEN);
    pd[1] = 32'h55;
    run_pkt("clr_on_done", 1'b0, 100, PKT_LEN, 1'b1);

    // reset after beat 4
    build_clean(PKT_LEN);
    run_pkt("abort", 1'b0, 100, 4, 1'b0);
    @(negedge aclk);
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    start_check   = 1'b0;
    @(negedge aclk);
    m_pkt = 0; m_err = 0; m_ed = 0; m_ek = 0; m_el = 0;
    chk("abort_tready", 32'(s_axis_tready), 32'd0);
    chk("abort_pkt_done", 32'(pkt_done), 32'd0);
    chk_status("abort");
    aresetn = 1'b1;
    build_clean(PKT_LEN);
    run_pkt("post_reset", 1'b0, 100, PKT_LEN, 1'b0);

    // randomized packets
    for (int p = 0; p < 12; p++) begin
      len = $urandom_range(2, PKT_LEN + 3);
      build_clean(len);
      if ($urandom_range(0, 3) == 0) begin
        int j;
        j = $urandom_range(0, len - 1);
        pd[j] = pd[j] ^ DATA_W'($urandom_range(1, 255));
      end
      if ($urandom_range(0, 3) == 0) begin
        int j;
        j = $urandom_range(0, len - 1);
        pk[j] = KEEP_W'($urandom_range(0, 14));
      end
      run_pkt("random", 1'($urandom_range(0, 1)), $urandom_range(30, 100), len,
              ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
